// File: rtl/modbus_uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// modbus_uart_pkg
// Shared definitions for the Modbus RTU UART receive path:
//   - receiver FSM states
//   - PARITY parameter encodings
//   - 16x oversample sample/vote points
//   - helpers for the 3-sample majority vote and the parity check
// ----------------------------------------------------------------------------
package modbus_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Sample points inside a 16-tick bit; the vote is taken on the last one.
    localparam logic [3:0] SC_SAMPLE_1 = 4'd7;
    localparam logic [3:0] SC_SAMPLE_2 = 4'd8;
    localparam logic [3:0] SC_VOTE     = 4'd9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // 1 when the received parity bit disagrees with the data under the
    // selected rule (odd=1 flips the expected value).
    function automatic logic parity_err(input logic pbit, input logic [7:0] data,
                                        input logic odd);
        return pbit ^ (^data) ^ odd;
    endfunction

endpackage

// File: rtl/modbus_uart_rx_if.sv
// ----------------------------------------------------------------------------
// modbus_uart_rx_if
// Received byte stream from the UART receiver to modbus_endpoint.
//   dout  : received byte, held until the next ready
//   ready : one-clk strobe, dout/rxerr valid
//   rxerr : parity or framing error, only ever high together with ready
// master = receiver (drives), slave = endpoint (consumes).
// ----------------------------------------------------------------------------
interface modbus_uart_rx_if;
    logic [7:0] dout;
    logic       ready;
    logic       rxerr;

    modport master (output dout, output ready, output rxerr);
    modport slave  (input  dout, input  ready, input  rxerr);
endinterface

// File: rtl/modbus_uart_rx_baud_tick.sv
// ----------------------------------------------------------------------------
// modbus_baud_tick
// Free-running divider producing a one-clk tick every CLK_DIV clocks.
//   clk   : system clock
//   reset : synchronous, active-high
//   clr   : synchronous restart of the divider phase (tick suppressed)
//   tick  : registered one-clk pulse in the last cycle of each period
// ----------------------------------------------------------------------------
module modbus_baud_tick #(
    parameter int CLK_DIV = 163
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] CNT_LAST = 16'(CLK_DIV - 1);
    // tick is registered, so it is set one count early to line up with CNT_LAST
    localparam logic [15:0] CNT_PRE  = 16'(CLK_DIV - 2);

    logic [15:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;

    // Next divider count and tick
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d  = 16'd0;
            tick_d = 1'b0;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = 16'd0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            tick_d = (cnt_q == CNT_PRE);
        end
    end

    // Divider state register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= 16'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/modbus_uart_rx.sv
// ----------------------------------------------------------------------------
// modbus_uart_rx
// RS-485 serial receiver: 1 start, 8 data LSB-first, optional parity, 1 or 2
// stop bits. 16x oversampling, majority vote of samples 7/8/9 of every bit.
//   clk    : system clock
//   reset  : synchronous, active-high
//   rxd    : asynchronous serial line, idle high
//   rx_out : byte stream to modbus_endpoint (dout/ready/rxerr)
// ----------------------------------------------------------------------------
module modbus_uart_rx
    import modbus_uart_pkg::*;
#(
    parameter int CLK_DIV   = 163,
    parameter int PARITY    = 2,
    parameter int STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rxd,
    modbus_uart_rx_if.master   rx_out
);

    logic       sync1_q, rs_q, rs_prev_q;
    logic [1:0] settle_q;
    logic       tick_s, start_edge_s, vote_s, vote_tick_s;
    logic [3:0] sc_inc_s;

    rx_state_e  state_q, state_d;
    logic [3:0] sc_q, sc_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       s7_q, s7_d, s8_q, s8_d;
    logic       perr_q, perr_d, ferr_q, ferr_d;
    logic       stop_idx_q, stop_idx_d;
    logic [7:0] dout_q, dout_d;
    logic       ready_q, ready_d, rxerr_q, rxerr_d;

    // Line synchronizer plus edge-history flop. The history flop is held low
    // until the synchronizer has flushed its reset value, so a line that is
    // low at reset release is never mistaken for a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            rs_q      <= 1'b1;
            rs_prev_q <= 1'b0;
            settle_q  <= 2'd0;
        end else begin
            sync1_q <= rxd;
            rs_q    <= sync1_q;
            if (settle_q == 2'd2) begin
                rs_prev_q <= rs_q;
                settle_q  <= settle_q;
            end else begin
                rs_prev_q <= 1'b0;
                settle_q  <= settle_q + 2'd1;
            end
        end
    end

    assign start_edge_s = (state_q == S_IDLE) & rs_prev_q & ~rs_q;

    modbus_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (start_edge_s),
        .tick  (tick_s)
    );

    assign sc_inc_s    = sc_q + 4'd1;
    assign vote_s      = maj3(s7_q, s8_q, rs_q);
    assign vote_tick_s = tick_s & (sc_inc_s == SC_VOTE);

    // Sample capture and receiver FSM next-state / output decode
    always_comb begin
        state_d    = state_q;
        sc_d       = sc_q;
        idx_d      = idx_q;
        data_d     = data_q;
        s7_d       = s7_q;
        s8_d       = s8_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        stop_idx_d = stop_idx_q;
        dout_d     = dout_q;
        ready_d    = 1'b0;
        rxerr_d    = 1'b0;

        if (tick_s) begin
            sc_d = sc_inc_s;
            if (sc_inc_s == SC_SAMPLE_1) begin
                s7_d = rs_q;
            end else if (sc_inc_s == SC_SAMPLE_2) begin
                s8_d = rs_q;
            end else begin
                s7_d = s7_q;
            end
        end else begin
            sc_d = sc_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_edge_s) begin
                    state_d    = S_START;
                    sc_d       = 4'd0;
                    idx_d      = 3'd0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    stop_idx_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (vote_tick_s) begin
                    if (vote_s) begin
                        state_d = S_IDLE;       // false start, no strobe
                    end else begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (vote_tick_s) begin
                    data_d[idx_q] = vote_s;
                    idx_d         = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (vote_tick_s) begin
                    perr_d  = parity_err(vote_s, data_q, (PARITY == PAR_ODD));
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (vote_tick_s) begin
                    ferr_d = ferr_q | ~vote_s;
                    if ((STOP_BITS == 2) && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                        state_d    = S_STOP;
                    end else begin
                        ready_d = 1'b1;
                        dout_d  = data_q;
                        rxerr_d = perr_q | ferr_q | ~vote_s;
                        // A low final stop vote means break/garbage: wait for
                        // the line to recover before arming for a new start.
                        state_d = vote_s ? S_IDLE : S_WAIT_HIGH;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_WAIT_HIGH: begin
                if (rs_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_HIGH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Receiver state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sc_q       <= 4'd0;
            idx_q      <= 3'd0;
            data_q     <= 8'h00;
            s7_q       <= 1'b1;
            s8_q       <= 1'b1;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop_idx_q <= 1'b0;
            dout_q     <= 8'h00;
            ready_q    <= 1'b0;
            rxerr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sc_q       <= sc_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            s7_q       <= s7_d;
            s8_q       <= s8_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            stop_idx_q <= stop_idx_d;
            dout_q     <= dout_d;
            ready_q    <= ready_d;
            rxerr_q    <= rxerr_d;
        end
    end

    assign rx_out.dout  = dout_q;
    assign rx_out.ready = ready_q;
    assign rx_out.rxerr = rxerr_q;

endmodule

// File: tb/tb_modbus_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_modbus_uart_rx
// Two receivers on CLK_DIV=4: dut_a (even parity, 1 stop) and dut_b (no
// parity, 2 stop bits). Frames are serialized bit by bit; a monitor collects
// every ready strobe; expectations come from the frame contents.
// ----------------------------------------------------------------------------
module tb_modbus_uart_rx;
    import modbus_uart_pkg::*;

    localparam int CLK_DIV  = 4;
    localparam int BIT_CLKS = 16 * CLK_DIV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a, reset_b, rxd_a, rxd_b;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   bad_quiet = 0;

    modbus_uart_rx_if if_a ();
    modbus_uart_rx_if if_b ();

    modbus_uart_rx #(.CLK_DIV(CLK_DIV), .PARITY(2), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset_a), .rxd(rxd_a), .rx_out(if_a.master));
    modbus_uart_rx #(.CLK_DIV(CLK_DIV), .PARITY(0), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset_b), .rxd(rxd_b), .rx_out(if_b.master));

    typedef struct packed {
        logic [7:0] d;
        logic       e;
        int         t;
    } strobe_t;

    strobe_t q_a[$];
    strobe_t q_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitors, plus rxerr must stay low outside of ready
    always @(negedge clk) begin
        if (if_a.ready === 1'b1) q_a.push_back('{d: if_a.dout, e: if_a.rxerr, t: cyc});
        if (if_b.ready === 1'b1) q_b.push_back('{d: if_b.dout, e: if_b.rxerr, t: cyc});
        if (if_a.ready !== 1'b1 && if_a.rxerr !== 1'b0) bad_quiet = bad_quiet + 1;
        if (if_b.ready !== 1'b1 && if_b.rxerr !== 1'b0) bad_quiet = bad_quiet + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start edge to ready: 2 sync clks + whole bits before the last stop bit + 9 ticks
    function automatic int exp_lat(input int sel);
        int npar  = (sel == 0) ? 1 : 0;
        int nstop = (sel == 0) ? 1 : 2;
        return 2 + (9 + npar + nstop - 1) * BIT_CLKS + 9 * CLK_DIV;
    endfunction

    // Reference: rxerr = parity rule violated (total ones of data+parity must
    // be even for dut_a) or any stop bit sampled low.
    function automatic bit model_rxerr(input int sel, input logic [7:0] b,
                                       input logic pbit, input logic [1:0] stop_low);
        bit perr = 1'b0;
        if (sel == 0) perr = ((($countones(b) + int'(pbit)) % 2) != 0);
        return perr || (stop_low != 2'b00);
    endfunction

    function automatic logic [15:0] crc16(input logic [7:0] msg [6]);
        logic [15:0] crc = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            crc = crc ^ {8'h00, msg[i]};
            for (int k = 0; k < 8; k++)
                crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
        end
        return crc;
    endfunction

    task automatic drive_line(input int sel, input logic v, input int n);
        if (sel == 0) rxd_a = v; else rxd_b = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_reset(input int sel, input logic v);
        if (sel == 0) reset_a = v; else reset_b = v;
    endtask

    // Serialize one frame. glitch_idx: bit position (0=start) carrying a
    // 4-clk inverted pulse around sample 8; reset_idx: bit position where
    // the DUT gets a 2-clk reset pulse.
    task automatic send_frame(input int sel, input logic [7:0] b, input bit flip,
                              input logic [1:0] stop_low, input int glitch_idx,
                              input int reset_idx, output int t0, output logic pbit);
        logic bits[$];
        logic v;
        int nstop = (sel == 0) ? 1 : 2;
        pbit = (^b) ^ flip;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (sel == 0) bits.push_back(pbit);
        for (int s = 0; s < nstop; s++) bits.push_back(~stop_low[s]);
        t0 = cyc;
        foreach (bits[i]) begin
            v = bits[i];
            if (i == glitch_idx) begin
                drive_line(sel, v, 30);
                drive_line(sel, ~v, 4);
                drive_line(sel, v, 30);
            end else if (i == reset_idx) begin
                drive_line(sel, v, 20);
                set_reset(sel, 1'b1);
                drive_line(sel, v, 2);
                set_reset(sel, 1'b0);
                drive_line(sel, v, BIT_CLKS - 22);
            end else begin
                drive_line(sel, v, BIT_CLKS);
            end
        end
    endtask

    task automatic get_strobe(input int sel, input string name, output strobe_t s, output bit ok);
        int waited = 0;
        while (((sel == 0) ? q_a.size() : q_b.size()) == 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        ok = 1'b1;
        s  = '0;
        if (((sel == 0) ? q_a.size() : q_b.size()) == 0) begin
            ok = 1'b0;
            n_checks++;
            n_err++;
            $display("FAIL %s: no ready strobe within 3000 clks, expected one", name);
        end else if (sel == 0) begin
            s = q_a.pop_front();
        end else begin
            s = q_b.pop_front();
        end
    endtask

    task automatic expect_strobe(input int sel, input string name, input logic [7:0] ed,
                                 input bit ee, input int t0, input bit chk_lat);
        strobe_t s;
        bit ok;
        int lat;
        get_strobe(sel, name, s, ok);
        if (ok) begin
            check({name, "_dout"}, 32'(s.d), 32'(ed));
            check({name, "_rxerr"}, 32'(s.e), 32'(ee));
            if (chk_lat) begin
                lat = s.t - t0;
                n_checks++;
                if (lat < exp_lat(sel) - 4 || lat > exp_lat(sel) + 4) begin
                    n_err++;
                    $display("FAIL %s_latency: got %0d clks, expected %0d +-4", name, lat, exp_lat(sel));
                end
            end
        end
    endtask

    typedef struct {
        logic [7:0] b;
        bit         flip;
        logic [1:0] stop_low;
        logic [7:0] exp_d;
        bit         exp_e;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #(10 * 200000);
        $display("FAIL watchdog: simulation exceeded 200000 clks");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0, t1;
        int ts[8];
        logic pb;
        logic [7:0] msg [6];
        logic [7:0] req [8];
        logic [15:0] crc;

        vecs[0] = '{8'hA7, 1'b1, 2'b00, 8'hA7, 1'b1};
        vecs[1] = '{8'h5A, 1'b0, 2'b00, 8'h5A, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 2'b00, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 2'b00, 8'hFF, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 2'b00, 8'h80, 1'b1};
        vecs[5] = '{8'h3C, 1'b0, 2'b01, 8'h3C, 1'b1};
        vecs[6] = '{8'h01, 1'b1, 2'b01, 8'h01, 1'b1};
        vecs[7] = '{8'hC9, 1'b0, 2'b00, 8'hC9, 1'b0};

        rxd_a = 1'b1; rxd_b = 1'b1; reset_a = 1'b1; reset_b = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_dout_a",  32'(if_a.dout),  32'h00);
        check("rst_ready_a", 32'(if_a.ready), 32'h0);
        check("rst_rxerr_a", 32'(if_a.rxerr), 32'h0);
        check("rst_dout_b",  32'(if_b.dout),  32'h00);
        check("rst_ready_b", 32'(if_b.ready), 32'h0);
        reset_a = 1'b0; reset_b = 1'b0;
        drive_line(0, 1'b1, 2 * BIT_CLKS);

        // Zero-gap pair, with latency
        send_frame(0, 8'h05, 1'b0, 2'b00, -1, -1, t0, pb);
        send_frame(0, 8'h03, 1'b0, 2'b00, -1, -1, t1, pb);
        expect_strobe(0, "pair0", 8'h05, 1'b0, t0, 1'b1);
        expect_strobe(0, "pair1", 8'h03, 1'b0, t1, 1'b1);
        drive_line(0, 1'b1, BIT_CLKS);

        // Table of parity / framing vectors
        for (int i = 0; i < 8; i++) begin
            send_frame(0, vecs[i].b, vecs[i].flip, vecs[i].stop_low, -1, -1, t0, pb);
            drive_line(0, 1'b1, BIT_CLKS);
            expect_strobe(0, $sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_e, t0, 1'b1);
        end

        // Break: stop bit low, line held low 30 bits -> exactly one strobe
        send_frame(0, 8'h12, 1'b0, 2'b01, -1, -1, t0, pb);
        drive_line(0, 1'b0, 30 * BIT_CLKS);
        check("brk_count", 32'(q_a.size()), 32'd1);
        expect_strobe(0, "brk", 8'h12, 1'b1, t0, 1'b1);
        drive_line(0, 1'b1, 2 * BIT_CLKS);
        check("brk_quiet", 32'(q_a.size()), 32'd0);
        send_frame(0, 8'h34, 1'b0, 2'b00, -1, -1, t0, pb);
        drive_line(0, 1'b1, BIT_CLKS);
        expect_strobe(0, "post_brk", 8'h34, 1'b0, t0, 1'b1);

        // Noise: short idle pulse, then an in-bit glitch on data bit 3
        drive_line(0, 1'b0, 6);
        drive_line(0, 1'b1, 3 * BIT_CLKS);
        check("noise_none", 32'(q_a.size()), 32'd0);
        send_frame(0, 8'hFF, 1'b0, 2'b00, 4, -1, t0, pb);
        drive_line(0, 1'b1, BIT_CLKS);
        expect_strobe(0, "glitch", 8'hFF, 1'b0, t0, 1'b1);

        // Reset during data bit 4 of 0x81: the frame is dropped. The low
        // parity bit that follows bit 7 is a genuine 1->0 edge, so it starts
        // a new frame reading the stop bit and idle as data: 0xFF, and a high
        // parity bit, which violates even parity.
        send_frame(0, 8'h81, 1'b0, 2'b00, -1, 5, t0, pb);
        check("rst_abort_none", 32'(q_a.size()), 32'd0);
        drive_line(0, 1'b1, 12 * BIT_CLKS);
        expect_strobe(0, "rst_ghost", 8'hFF, 1'b1, 0, 1'b0);
        send_frame(0, 8'h81, 1'b0, 2'b00, -1, -1, t0, pb);
        drive_line(0, 1'b1, BIT_CLKS);
        expect_strobe(0, "rst_next", 8'h81, 1'b0, t0, 1'b1);

        // Randomized frames against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            bit         flip;
            logic [1:0] sl;
            int         gap;
            b    = 8'($urandom_range(0, 255));
            flip = ($urandom_range(0, 3) == 0);
            sl   = ($urandom_range(0, 4) == 0) ? 2'b01 : 2'b00;
            gap  = (sl != 2'b00) ? $urandom_range(1, 2) : $urandom_range(0, 2);
            send_frame(0, b, flip, sl, -1, -1, t0, pb);
            expect_strobe(0, $sformatf("rnd%0d", i), b, model_rxerr(0, b, pb, sl), t0, 1'b1);
            drive_line(0, 1'b1, gap * BIT_CLKS);
        end

        // dut_b: Modbus read request, zero gap, no parity, 2 stop bits
        msg = '{8'h05, 8'h03, 8'h12, 8'h34, 8'h00, 8'h04};
        crc = crc16(msg);
        for (int i = 0; i < 6; i++) req[i] = msg[i];
        req[6] = crc[7:0];
        req[7] = crc[15:8];
        drive_line(1, 1'b1, BIT_CLKS);
        for (int i = 0; i < 8; i++) send_frame(1, req[i], 1'b0, 2'b00, -1, -1, ts[i], pb);
        for (int i = 0; i < 8; i++)
            expect_strobe(1, $sformatf("req%0d", i), req[i], 1'b0, ts[i], 1'b1);

        // dut_b: either stop bit low is a framing error
        send_frame(1, 8'h55, 1'b0, 2'b10, -1, -1, t0, pb);
        drive_line(1, 1'b1, BIT_CLKS);
        expect_strobe(1, "stop2_low", 8'h55, model_rxerr(1, 8'h55, pb, 2'b10), t0, 1'b1);
        send_frame(1, 8'hC3, 1'b0, 2'b01, -1, -1, t0, pb);
        drive_line(1, 1'b1, BIT_CLKS);
        expect_strobe(1, "stop1_low", 8'hC3, model_rxerr(1, 8'hC3, pb, 2'b01), t0, 1'b1);
        send_frame(1, 8'h7E, 1'b0, 2'b00, -1, -1, t0, pb);
        drive_line(1, 1'b1, BIT_CLKS);
        expect_strobe(1, "b_recover", 8'h7E, 1'b0, t0, 1'b1);

        drive_line(0, 1'b1, 2 * BIT_CLKS);
        check("tail_a", 32'(q_a.size()), 32'd0);
        check("tail_b", 32'(q_b.size()), 32'd0);
        check("rxerr_quiet", 32'(bad_quiet), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
